ifid_queue: RTL
===============

Name: ifid_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction queue between the fetch stage and the decode stage.
- Each entry holds the instruction, its PC and any fetch-stage exception code.
- Uses a valid/ready handshake on both sides and supports a one-cycle flush on branch, exception or eret redirect.
- At the head it derives PC+4/PC+8 and the decode-stage exception code, including reserved-instruction (RI) detection.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- EXC_W, 5, exception code width.
- RI_CODE, 10, ExcCode driven for a reserved instruction.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  32  fetched instruction.
- in_pc  in  32  PC of the fetched instruction.
- in_exc  in  EXC_W  fetch exception code (e.g. 4 = AdEL); 0 = none.
- flush  in  1  discard all entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes the head (not stalled).
- IR_D  out  32  head instruction; 0 when empty.
- PC_D  out  32  head PC; 0 when empty.
- PC4_D  out  32  PC_D+4, mod 2^32.
- PC8_D  out  32  PC_D+8, mod 2^32.
- excode_D  out  EXC_W  head exception code; 0 when empty.
- count  out  clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (async assert, sync-safe deassert): wr_ptr=rd_ptr=0, count=0. Then out_valid=0, IR_D=PC_D=0, PC4_D=4, PC8_D=8, excode_D=0, in_ready=1. Storage contents are don't-care.
- Push = in_valid && in_ready && !flush. Pop = out_valid && out_ready && !flush.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready. When full, a simultaneous pop does not enable a push.
- Push writes entry[wr_ptr]; wr_ptr wraps DEPTH-1 -> 0. Pop advances rd_ptr with the same wrap.
- count: +1 on push only, -1 on pop only, unchanged on push+pop. It never exceeds DEPTH and never goes below 0.
- Latency: an instruction pushed in cycle N is visible at the head in cycle N+1 when the queue was empty. There is no combinational bypass.
- Head outputs are combinational from entry[rd_ptr] when count>0. When empty they are forced to the bubble values (IR_D=0, PC_D=0, excode_D=0).
- Flush takes priority over push and pop in the same cycle. Next cycle: count=0, pointers reset to 0, out_valid=0.
- Stall is out_ready=0: the head is held, and push continues until full.
- excode_D priority, for a valid head:
  - stored in_exc when nonzero;
  - else RI_CODE when the instruction is not in the supported set;
  - else 0.
  - in_exc is captured per entry and never recomputed.
- Supported set (RI=0):
  - op 000000 with funct in {jr, jalr, add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, mult, multu, div, divu, mfhi, mflo, mthi, mtlo};
  - op in {j, jal, beq, bne, blez, bgtz, lui, ori, andi, xori, addi, addiu, slti, sltiu, lw, lb, lbu, lh, lhu, sw, sb, sh};
  - op 000001 with rt in {00000, 00001};
  - op 010000 with rs in {00000, 00100};
  - exact word 0x42000018 (eret).
  - Instruction 0x00000000 (sll nop) is supported.

Decomposition:
- Shared package `cpu_defs_pkg`:
  - opcode/funct/rt/rs field constants;
  - ERET word;
  - ExcCode constants (ADEL=4, RI=10).
- Sub-module `ri_decode`: combinational, 32-bit instruction in, 1-bit reserved out. It is reusable by later decode logic.

Test Plan:
- Reset: drive reset=0 mid-stream with count=2 -> immediately count=0, out_valid=0, IR_D=0, PC4_D=4, in_ready=1.
- Fill: DEPTH=2, out_ready=0, push pc 0x3000 instr 0x24010001 then pc 0x3004 -> count=2, in_ready=0. A third push is ignored and PC_D stays 0x3000.
- Push+pop with count=1, then continuous streaming over 6 instructions -> count stays 1. Order is preserved across pointer wrap, PC8_D = PC_D+8.
- Flush and in_valid=1 in the same cycle with count=2 -> next cycle count=0, out_valid=0, and the flushed-cycle instruction is absent.
- RI: push 0xFC000000 -> excode_D=10. Push 0x42000018 -> 0. Push 0x00000000 -> 0. Push op 000001 rt=00010 -> 10.
- Fetch exception priority: push in_exc=4 with instr 0xFC000000 -> excode_D=4. The following valid instruction shows 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: instruction field encodings, the eret word and exception codes.
package cpu_defs_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned EXC_W   = 5;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM  = 6'h01;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ    = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ    = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI    = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU   = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI    = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU   = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI    = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI     = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI    = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI     = 6'h0F;
  localparam logic [OP_W-1:0] OP_COP0    = 6'h10;
  localparam logic [OP_W-1:0] OP_LB      = 6'h20;
  localparam logic [OP_W-1:0] OP_LH      = 6'h21;
  localparam logic [OP_W-1:0] OP_LW      = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU     = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU     = 6'h25;
  localparam logic [OP_W-1:0] OP_SB      = 6'h28;
  localparam logic [OP_W-1:0] OP_SH      = 6'h29;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [FUNCT_W-1:0] FN_SLL   = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL   = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA   = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_SLLV  = 6'h04;
  localparam logic [FUNCT_W-1:0] FN_SRLV  = 6'h06;
  localparam logic [FUNCT_W-1:0] FN_SRAV  = 6'h07;
  localparam logic [FUNCT_W-1:0] FN_JR    = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_JALR  = 6'h09;
  localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FN_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FN_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FN_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FN_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'h1B;
  localparam logic [FUNCT_W-1:0] FN_ADD   = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU  = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB   = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU  = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND   = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR    = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR   = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR   = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT   = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLTU  = 6'h2B;

  // REGIMM rt selectors (bltz, bgez) and COP0 rs selectors (mfc0, mtc0)
  localparam logic [REG_W-1:0] RT_BLTZ = 5'h00;
  localparam logic [REG_W-1:0] RT_BGEZ = 5'h01;
  localparam logic [REG_W-1:0] RS_MF   = 5'h00;
  localparam logic [REG_W-1:0] RS_MT   = 5'h04;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;

endpackage

// File: rtl/ri_decode.sv
// Reserved-instruction detector: flags any word outside the supported instruction set.
module ri_decode
  import cpu_defs_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        reserved_o
);

  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;
  logic [REG_W-1:0]   rs;
  logic [REG_W-1:0]   rt;

  assign op    = instr_i[31:26];
  assign rs    = instr_i[25:21];
  assign rt    = instr_i[20:16];
  assign funct = instr_i[5:0];

  always_comb begin
    reserved_o = 1'b1;
    if (instr_i == ERET_WORD) begin
      reserved_o = 1'b0;
    end else begin
      unique case (op)
        OP_SPECIAL: begin
          case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_JR, FN_JALR, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: reserved_o = 1'b0;
            default: reserved_o = 1'b1;
          endcase
        end
        OP_REGIMM: reserved_o = !((rt == RT_BLTZ) || (rt == RT_BGEZ));
        OP_COP0:   reserved_o = !((rs == RS_MF) || (rs == RS_MT));
        OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: reserved_o = 1'b0;
        default: reserved_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ifid_queue.sv
// DEPTH-entry IF/ID instruction queue with valid/ready on both sides, flush,
// and head-side PC+4/PC+8 and decode exception code derivation.
module ifid_queue
  import cpu_defs_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned EXC_W   = 5,
  parameter int unsigned RI_CODE = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc,
  input  logic [EXC_W-1:0]           in_exc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                IR_D,
  output logic [31:0]                PC_D,
  output logic [31:0]                PC4_D,
  output logic [31:0]                PC8_D,
  output logic [EXC_W-1:0]           excode_D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [EXC_W-1:0] exc_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_c, pop_c, head_ri_c;
  logic [31:0]      head_instr_c, head_pc_c;
  logic [EXC_W-1:0] head_exc_c;

  // Ready comes only from registered occupancy, so a pop never frees a slot in the same cycle
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid && in_ready && !flush;
  assign pop_c     = out_valid && out_ready && !flush;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
      if (pop_c)  rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
      if (push_c && !pop_c)      count_d = CNT_W'(count_q + CNT_W'(1));
      else if (pop_c && !push_c) count_d = CNT_W'(count_q - CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy decides what is visible
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
      exc_mem[wr_ptr_q]   <= in_exc;
    end
  end

  always_comb begin
    head_instr_c = '0;
    head_pc_c    = '0;
    head_exc_c   = '0;
    if (out_valid) begin
      head_instr_c = instr_mem[rd_ptr_q];
      head_pc_c    = pc_mem[rd_ptr_q];
      head_exc_c   = exc_mem[rd_ptr_q];
    end
  end

  ri_decode u_ri_decode (
    .instr_i    (head_instr_c),
    .reserved_o (head_ri_c)
  );

  // Fetch exception wins over RI; a bubble reports nothing
  always_comb begin
    excode_D = '0;
    if (out_valid) begin
      if (head_exc_c != '0) excode_D = head_exc_c;
      else if (head_ri_c)   excode_D = EXC_W'(RI_CODE);
    end
  end

  assign IR_D  = head_instr_c;
  assign PC_D  = head_pc_c;
  assign PC4_D = head_pc_c + 32'd4;
  assign PC8_D = head_pc_c + 32'd8;

endmodule
